// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, RS(n,k) t=2 generator and encoder FSM encoding.
// Field polynomial 0x11D with alpha = 0x02.
package rs_pkg;

  typedef logic [7:0] sym_t;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int         N_PAR   = 4;

  localparam sym_t G0 = 8'h40;
  localparam sym_t G1 = 8'h78;
  localparam sym_t G2 = 8'h36;
  localparam sym_t G3 = 8'h0F;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_DATA = 3'b010;
  localparam logic [2:0] ST_PAR  = 3'b100;

  localparam logic [1:0] PCNT_LAST = 2'(N_PAR - 1);

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0])
               : {x[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/gf2m8_cmul.sv
// Constant-coefficient GF(2^8) multiplier; folds to a small XOR network.
module gf2m8_cmul
  import rs_pkg::*;
#(
  parameter logic [7:0] COEF = 8'h01
) (
  input  logic [7:0] i_a,
  output logic [7:0] o_p
);

  assign o_p = gf_mul(i_a, COEF);

endmodule

// File: rtl/s0_rs_enc.sv
// Systematic RS(K_SYM+4, K_SYM) encoder over GF(2^8), t=2.
// Data passes through registered; 4 parity symbols follow, high degree first.
module s0_rs_enc
  import rs_pkg::*;
#(
  parameter int K_SYM = 251
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic       enc_busy
);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_pcnt;
  sym_t       r_p0, r_p1, r_p2, r_p3;

  logic       w_acc;
  logic       w_clr;
  logic       w_last;
  logic [7:0] w_cnt_nx;
  sym_t       w_fb;
  sym_t       w_m0, w_m1, w_m2, w_m3;

  assign din_rdy  = ~r_state[2];
  assign enc_busy = ~r_state[0];
  assign w_acc    = din_vld & din_rdy;

  // In IDLE the LFSR is treated as zero so a new codeword never sees stale state
  assign w_clr    = r_state[0];
  assign w_fb     = din ^ (w_clr ? 8'h00 : r_p3);
  assign w_cnt_nx = w_clr ? 8'd1 : r_cnt + 8'd1;
  assign w_last   = (w_cnt_nx == 8'(K_SYM));

  gf2m8_cmul #(.COEF(G0)) u_m0 (.i_a(w_fb), .o_p(w_m0));
  gf2m8_cmul #(.COEF(G1)) u_m1 (.i_a(w_fb), .o_p(w_m1));
  gf2m8_cmul #(.COEF(G2)) u_m2 (.i_a(w_fb), .o_p(w_m2));
  gf2m8_cmul #(.COEF(G3)) u_m3 (.i_a(w_fb), .o_p(w_m3));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_p3     <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      unique case (1'b1)
        r_state[0], r_state[1]: begin
          if (w_acc) begin
            dout     <= din;
            dout_vld <= 1'b1;
            dout_sop <= r_state[0];
            r_cnt    <= w_cnt_nx;
            r_p3     <= (w_clr ? 8'h00 : r_p2) ^ w_m3;
            r_p2     <= (w_clr ? 8'h00 : r_p1) ^ w_m2;
            r_p1     <= (w_clr ? 8'h00 : r_p0) ^ w_m1;
            r_p0     <= w_m0;
            r_pcnt   <= '0;
            r_state  <= w_last ? ST_PAR : ST_DATA;
          end
        end
        r_state[2]: begin
          dout     <= r_p3;
          dout_vld <= 1'b1;
          r_p3     <= r_p2;
          r_p2     <= r_p1;
          r_p1     <= r_p0;
          r_p0     <= '0;
          r_pcnt   <= r_pcnt + 2'd1;
          if (r_pcnt == PCNT_LAST) begin
            dout_eop <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s0_rs_enc.sv
// Directed bench for s0_rs_enc with K_SYM = 4, 251 and 1 instances.
// Output symbols are collected on the falling edge and compared per codeword.
module tb_s0_rs_enc;

  logic       clk;
  logic       rst;
  logic [7:0] din_a  [3];
  logic       vld_a  [3];
  logic       rdy_a  [3];
  logic [7:0] dout_a [3];
  logic       vo_a   [3];
  logic       sop_a  [3];
  logic       eop_a  [3];
  logic       busy_a [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lo0    = 0;

  logic [9:0] q   [$];
  int         tq  [$];
  logic [7:0] eq  [$];

  s0_rs_enc #(.K_SYM(4)) u_k4 (
    .clk(clk), .rst(rst),
    .din(din_a[0]), .din_vld(vld_a[0]), .din_rdy(rdy_a[0]),
    .dout(dout_a[0]), .dout_vld(vo_a[0]),
    .dout_sop(sop_a[0]), .dout_eop(eop_a[0]),
    .enc_busy(busy_a[0])
  );

  s0_rs_enc #(.K_SYM(251)) u_k251 (
    .clk(clk), .rst(rst),
    .din(din_a[1]), .din_vld(vld_a[1]), .din_rdy(rdy_a[1]),
    .dout(dout_a[1]), .dout_vld(vo_a[1]),
    .dout_sop(sop_a[1]), .dout_eop(eop_a[1]),
    .enc_busy(busy_a[1])
  );

  s0_rs_enc #(.K_SYM(1)) u_k1 (
    .clk(clk), .rst(rst),
    .din(din_a[2]), .din_vld(vld_a[2]), .din_rdy(rdy_a[2]),
    .dout(dout_a[2]), .dout_vld(vo_a[2]),
    .dout_sop(sop_a[2]), .dout_eop(eop_a[2]),
    .enc_busy(busy_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vo_a[i]) begin
        q.push_back({eop_a[i], sop_a[i], dout_a[i]});
        tq.push_back(cyc);
      end
    end
    if (!rdy_a[0]) lo0 <= lo0 + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snd(input int u, input logic [7:0] d);
    int n;
    n = 0;
    din_a[u] = d;
    vld_a[u] = 1'b1;
    while (!rdy_a[u] && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy_a[u]) check("rdy_timeout", 32'(rdy_a[u]), 1);
    @(posedge clk);
    #1;
    vld_a[u] = 1'b0;
  endtask

  // n symbols expected, codeword length L, eq holds known leading symbols
  task automatic chk_cw(input string tag, input int n,
                        input int L, input bit cont);
    check({tag, "_len"}, q.size(), n);
    if (q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        if (i < eq.size()) check({tag, "_dat"}, q[i][7:0], eq[i]);
        check({tag, "_sop"}, 32'(q[i][8]), 32'(i % L == 0));
        check({tag, "_eop"}, 32'(q[i][9]), 32'(i % L == L - 1));
      end
      if (cont) check({tag, "_gap"}, tq[n-1] - tq[0], n - 1);
    end
  endtask

  task automatic clr();
    q.delete();
    tq.delete();
    eq.delete();
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] root;
    int         k;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_a[i] = 8'h00;
      vld_a[i] = 1'b0;
    end
    tick(3);
    check("rst_dout", dout_a[0], 0);
    check("rst_vld",  32'(vo_a[0]), 0);
    check("rst_sop",  32'(sop_a[0]), 0);
    check("rst_eop",  32'(eop_a[0]), 0);
    check("rst_busy", 32'(busy_a[0]), 0);
    check("rst_rdy",  32'(rdy_a[0]), 1);
    rst = 1'b0;
    tick(1);

    // unit impulse: parity equals the generator's low coefficients
    snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h01);
    check("A_busy", 32'(busy_a[0]), 1);
    tick(8);
    eq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    chk_cw("A", 8, 8, 1);
    check("A_idle", 32'(busy_a[0]), 0);
    clr();

    snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h02);
    tick(8);
    eq = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h1E, 8'h6C, 8'hF0, 8'h80};
    chk_cw("B", 8, 8, 1);
    clr();

    // back-to-back with valid held high across the parity phase
    lo0 = 0;
    snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h01);
    snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h00); snd(0, 8'h02);
    tick(8);
    eq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h0F, 8'h36, 8'h78, 8'h40,
           8'h00, 8'h00, 8'h00, 8'h02, 8'h1E, 8'h6C, 8'hF0, 8'h80};
    chk_cw("B2B", 16, 8, 1);
    check("B2B_rdy_lo", lo0, 8);
    clr();

    // abort at cnt=100
    for (int i = 0; i < 100; i++) snd(1, 8'(i * 7 + 3));
    check("R_busy_pre", 32'(busy_a[1]), 1);
    rst = 1'b1;
    tick(1);
    check("R_dout", dout_a[1], 0);
    check("R_vld",  32'(vo_a[1]), 0);
    check("R_sop",  32'(sop_a[1]), 0);
    check("R_eop",  32'(eop_a[1]), 0);
    check("R_busy", 32'(busy_a[1]), 0);
    rst = 1'b0;
    clr();
    tick(10);
    check("R_no_tail", q.size(), 0);
    clr();

    // full-length random codeword with random input gaps
    for (int i = 0; i < 251; i++) begin
      k = $urandom_range(0, 2);
      tick(k);
      eq.push_back(8'($urandom_range(0, 255)));
      snd(1, eq[i]);
    end
    tick(10);
    chk_cw("C", 255, 255, 0);
    root = 8'h01;
    for (int j = 0; j < 4; j++) begin
      s = 8'h00;
      for (int i = 0; i < q.size(); i++) s = gmul(s, root) ^ q[i][7:0];
      check("C_synd", s, 0);
      root = gmul(root, 8'h02);
    end
    clr();

    snd(2, 8'h01);
    tick(8);
    eq = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    chk_cw("K1", 5, 5, 1);
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
